// File: rtl/vending_pkg.sv
// Shared encodings for the vending controller: FSM states, change-coin indices
// and a width helper.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] COIN_IDX0 = 2'd0;
  localparam logic [1:0] COIN_IDX1 = 2'd1;
  localparam logic [1:0] COIN_IDX2 = 2'd2;
  localparam logic [1:0] COIN_IDX3 = 2'd3;

  // Minimum of 1 so a 1-entry range still yields a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Vend and change handshakes between the controller (master) and the
// dispenser / coin hopper (slave).
interface vending_controller_if #(
  parameter int ITEM_W = 3
) ();
  logic              vend_valid;
  logic [ITEM_W-1:0] vend_item;
  logic              vend_ack;
  logic              chg_valid;
  logic [1:0]        chg_coin;
  logic              chg_ready;

  modport master (output vend_valid, vend_item, chg_valid, chg_coin,
                  input  vend_ack, chg_ready);
  modport slave  (input  vend_valid, vend_item, chg_valid, chg_coin,
                  output vend_ack, chg_ready);
endinterface

// File: rtl/vending_edge_detect.sv
// Rising-edge detector; history resets to ones so lines held high through
// reset never produce an event.
module vending_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_evt
);
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (!rst) r_prev <= '1;
    else      r_prev <= i_in;
  end

  assign o_evt = i_in & ~r_prev;
endmodule

// File: rtl/vending_controller.sv
// Vending controller: credit accumulation, item selection, handshaked vend
// and greedy change return with inactivity auto-refund.
module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS   = 5,
  parameter int PRICE_W     = 7,
  parameter int MAX_CREDIT  = 99,
  parameter int COIN0       = 1,
  parameter int COIN1       = 5,
  parameter int COIN2       = 10,
  parameter int COIN3       = 20,
  parameter int TIMEOUT_CYC = 1000000,
  parameter bit AUTO_CHANGE = 1'b1,
  localparam int ITEM_W     = clog2(NUM_ITEMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   coin_in,
  input  logic                         btn_l,
  input  logic                         btn_r,
  input  logic                         btn_ok,
  input  logic                         btn_cancel,
  input  logic [NUM_ITEMS*PRICE_W-1:0] price_tbl,
  vending_controller_if.master         vif,
  output logic [PRICE_W-1:0]           credit,
  output logic [ITEM_W-1:0]            sel_idx,
  output logic [PRICE_W-1:0]           sel_price,
  output logic [NUM_ITEMS-1:0]         avail,
  output logic                         coin_reject,
  output logic                         deny,
  output logic [1:0]                   state_o
);
  localparam int TMO_W = clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ITEM_W-1:0] SEL_LAST = ITEM_W'(NUM_ITEMS - 1);

  function automatic logic [PRICE_W:0] coin_val(input logic [1:0] k);
    case (k)
      COIN_IDX0: coin_val = (PRICE_W+1)'(COIN0);
      COIN_IDX1: coin_val = (PRICE_W+1)'(COIN1);
      COIN_IDX2: coin_val = (PRICE_W+1)'(COIN2);
      default:   coin_val = (PRICE_W+1)'(COIN3);
    endcase
  endfunction

  function automatic logic [1:0] change_idx(input logic [PRICE_W-1:0] c);
    logic [PRICE_W:0] cx;
    cx = {1'b0, c};
    if      (cx >= coin_val(COIN_IDX3)) change_idx = COIN_IDX3;
    else if (cx >= coin_val(COIN_IDX2)) change_idx = COIN_IDX2;
    else if (cx >= coin_val(COIN_IDX1)) change_idx = COIN_IDX1;
    else                                change_idx = COIN_IDX0;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [PRICE_W-1:0] r_credit, w_credit_nxt;
  logic [ITEM_W-1:0]  r_sel, w_sel_nxt;
  logic [ITEM_W-1:0]  r_item, w_item_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic               r_reject, w_reject;
  logic               r_deny, w_deny;

  logic [7:0]         w_evt;
  logic [3:0]         w_coin_evt;
  logic               w_l, w_r, w_ok, w_cancel;
  logic [1:0]         w_coin_k;
  logic               w_coin_one;
  logic [PRICE_W:0]   w_coin_sum;
  logic [1:0]         w_chg_k;
  logic [PRICE_W-1:0] w_chg_val;

  vending_edge_detect #(.WIDTH(8)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .i_in ({btn_cancel, btn_ok, btn_r, btn_l, coin_in}),
    .o_evt(w_evt)
  );

  assign w_coin_evt = w_evt[3:0];
  assign w_l        = w_evt[4];
  assign w_r        = w_evt[5];
  assign w_ok       = w_evt[6];
  assign w_cancel   = w_evt[7];

  always_comb begin
    w_coin_k = COIN_IDX0;
    if      (w_coin_evt[3]) w_coin_k = COIN_IDX3;
    else if (w_coin_evt[2]) w_coin_k = COIN_IDX2;
    else if (w_coin_evt[1]) w_coin_k = COIN_IDX1;
  end

  assign w_coin_one = (w_coin_evt != 4'd0) && ((w_coin_evt & (w_coin_evt - 4'd1)) == 4'd0);
  assign w_coin_sum = {1'b0, r_credit} + coin_val(w_coin_k);
  assign w_chg_k    = change_idx(r_credit);
  assign w_chg_val  = coin_val(w_chg_k)[PRICE_W-1:0];
  assign sel_price  = price_tbl[int'(r_sel)*PRICE_W +: PRICE_W];

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      avail[i] = (r_credit >= price_tbl[i*PRICE_W +: PRICE_W]);
  end

  // State and registered datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_sel    <= '0;
      r_tmo    <= '0;
      r_reject <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_sel    <= w_sel_nxt;
      r_tmo    <= w_tmo_nxt;
      r_reject <= w_reject;
      r_deny   <= w_deny;
    end
  end

  always_ff @(posedge clk) r_item <= w_item_nxt;

  // Next state; cancel dominates ok, and any coin alongside either is refused
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_sel_nxt    = r_sel;
    w_item_nxt   = r_item;
    w_tmo_nxt    = '0;
    w_reject     = 1'b0;
    w_deny       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cancel) begin
          if (r_credit != '0) w_state_nxt = ST_CHANGE;
        end else if (w_ok) begin
          if (r_credit >= sel_price) begin
            w_credit_nxt = r_credit - sel_price;
            w_item_nxt   = r_sel;
            w_state_nxt  = ST_VEND;
          end else begin
            w_deny = 1'b1;
          end
        end else if (w_coin_one && w_coin_sum <= (PRICE_W+1)'(MAX_CREDIT)) begin
          w_credit_nxt = w_coin_sum[PRICE_W-1:0];
        end
        w_reject = (w_coin_evt != 4'd0) &&
                   (w_cancel || w_ok || !w_coin_one ||
                    w_coin_sum > (PRICE_W+1)'(MAX_CREDIT));
        if (w_l && !w_r)
          w_sel_nxt = (r_sel == '0) ? SEL_LAST : r_sel - 1'b1;
        else if (w_r && !w_l)
          w_sel_nxt = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
        if (r_credit != '0 && w_evt == 8'd0) begin
          if (r_tmo == TMO_LAST) w_state_nxt = ST_CHANGE;
          else                   w_tmo_nxt   = r_tmo + 1'b1;
        end
      end
      ST_VEND: begin
        w_reject = (w_coin_evt != 4'd0);
        if (vif.vend_ack)
          w_state_nxt = (AUTO_CHANGE && r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        w_reject = (w_coin_evt != 4'd0);
        if (r_credit == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (vif.chg_ready) begin
          w_credit_nxt = r_credit - w_chg_val;
          if (r_credit == w_chg_val) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    vif.vend_valid = (r_state == ST_VEND);
    vif.vend_item  = r_item;
    vif.chg_valid  = (r_state == ST_CHANGE);
    vif.chg_coin   = (r_state == ST_CHANGE) ? w_chg_k : COIN_IDX0;
    credit         = r_credit;
    sel_idx        = r_sel;
    coin_reject    = r_reject;
    deny           = r_deny;
    state_o        = r_state;
  end
endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller with prices {7,5,6,10,8} and a
// 16-cycle inactivity timeout.
module tb_vending_controller;
  localparam int NI = 5;
  localparam int PW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    lines = 8'd0;
  logic [NI*PW-1:0] price_tbl;
  logic [PW-1:0] credit, sel_price;
  logic [2:0]    sel_idx;
  logic [NI-1:0] avail;
  logic          coin_reject, deny;
  logic [1:0]    state_o;
  int            n_chk = 0;
  int            n_fail = 0;

  vending_controller_if #(.ITEM_W(3)) vif ();

  vending_controller #(.NUM_ITEMS(NI), .PRICE_W(PW), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_in    (lines[3:0]),
    .btn_l      (lines[4]),
    .btn_r      (lines[5]),
    .btn_ok     (lines[6]),
    .btn_cancel (lines[7]),
    .price_tbl  (price_tbl),
    .vif        (vif),
    .credit     (credit),
    .sel_idx    (sel_idx),
    .sel_price  (sel_price),
    .avail      (avail),
    .coin_reject(coin_reject),
    .deny       (deny),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line numbers: 0..3 coins, 4 left, 5 right, 6 ok, 7 cancel
  task automatic press(input int ln);
    lines[ln] = 1'b1;
    step();
    lines[ln] = 1'b0;
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    lines[7] = 1'b1;
    step();
    lines[7] = 1'b0;
    vif.chg_ready = 1'b1;
    while (state_o != 2'd0 && n < 40) begin
      step();
      n++;
    end
    vif.chg_ready = 1'b0;
    chk({tag, "_idle"}, state_o, 2'd0);
    chk({tag, "_credit"}, credit, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_k [4];
    logic [6:0] exp_c [4];
    exp_k = '{2'd3, 2'd1, 2'd0, 2'd0};
    exp_c = '{7'd7, 7'd2, 7'd1, 7'd0};
    price_tbl = {7'd8, 7'd10, 7'd6, 7'd5, 7'd7};
    vif.vend_ack  = 1'b0;
    vif.chg_ready = 1'b0;
    repeat (3) step();
    chk("rst_state", state_o, 0);
    chk("rst_credit", credit, 0);
    chk("rst_sel", sel_idx, 0);
    chk("rst_vvalid", vif.vend_valid, 0);
    chk("rst_cvalid", vif.chg_valid, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_deny", deny, 0);
    chk("rst_coin", vif.chg_coin, 0);
    rst = 1'b1;
    step();

    // Buy item 3 with 15, receive a 5 back
    press(1);
    press(2);
    chk("t1_credit", credit, 15);
    chk("t1_avail", avail, 5'b11111);
    repeat (3) press(5);
    chk("t1_sel", sel_idx, 3);
    chk("t1_price", sel_price, 10);
    lines[6] = 1'b1;
    step();
    lines[6] = 1'b0;
    chk("t1_vstate", state_o, 1);
    chk("t1_vvalid", vif.vend_valid, 1);
    chk("t1_vitem", vif.vend_item, 3);
    chk("t1_vcredit", credit, 5);
    step();
    chk("t1_vhold", vif.vend_valid, 1);
    vif.vend_ack = 1'b1;
    step();
    vif.vend_ack = 1'b0;
    chk("t1_cstate", state_o, 2);
    chk("t1_vdrop", vif.vend_valid, 0);
    chk("t1_cvalid", vif.chg_valid, 1);
    chk("t1_ccoin", vif.chg_coin, 1);
    vif.chg_ready = 1'b1;
    step();
    vif.chg_ready = 1'b0;
    chk("t1_end_credit", credit, 0);
    chk("t1_end_state", state_o, 0);
    chk("t1_end_cvalid", vif.chg_valid, 0);

    // Navigation wrap
    press(5);
    press(5);
    chk("nav_r_wrap", sel_idx, 0);
    press(4);
    chk("nav_l_wrap", sel_idx, 4);
    press(5);
    chk("nav_r", sel_idx, 0);
    lines[4] = 1'b1; lines[5] = 1'b1;
    step();
    lines[4] = 1'b0; lines[5] = 1'b0;
    step();
    chk("nav_both", sel_idx, 0);

    // Two coin edges together
    lines[3:0] = 4'b0011;
    step();
    lines[3:0] = 4'b0000;
    chk("dual_reject", coin_reject, 1);
    chk("dual_credit", credit, 0);
    step();
    chk("dual_reject_end", coin_reject, 0);

    // Overflow rejection near the ceiling
    repeat (4) press(3);
    press(2);
    chk("ovf_base", credit, 90);
    lines[3] = 1'b1;
    step();
    lines[3] = 1'b0;
    chk("ovf_reject", coin_reject, 1);
    chk("ovf_credit", credit, 90);
    step();
    chk("ovf_reject_end", coin_reject, 0);
    press(1);
    chk("ovf_add5", credit, 95);
    drain("ovf_drain");

    // Insufficient credit
    press(1);
    press(0);
    press(4);
    press(4);
    chk("deny_sel", sel_idx, 3);
    chk("deny_avail", avail, 5'b00110);
    lines[6] = 1'b1;
    step();
    lines[6] = 1'b0;
    chk("deny_pulse", deny, 1);
    chk("deny_state", state_o, 0);
    chk("deny_credit", credit, 6);
    step();
    chk("deny_end", deny, 0);
    drain("deny_drain");

    // Inactivity refund
    press(3);
    press(1);
    press(0);
    press(0);
    chk("tmo_credit", credit, 27);
    repeat (14) step();
    chk("tmo_before", state_o, 0);
    step();
    chk("tmo_fire", state_o, 2);
    for (int i = 0; i < 4; i++) begin
      vif.chg_ready = 1'b0;
      step();
      chk("tmo_cvalid", vif.chg_valid, 1);
      chk("tmo_coin", vif.chg_coin, exp_k[i]);
      vif.chg_ready = 1'b1;
      step();
      vif.chg_ready = 1'b0;
      chk("tmo_credit_step", credit, exp_c[i]);
    end
    chk("tmo_end_state", state_o, 0);
    chk("tmo_end_cvalid", vif.chg_valid, 0);

    // Reset during change, coin held high across release
    press(2);
    press(0);
    lines[7] = 1'b1;
    step();
    lines[7] = 1'b0;
    chk("rmid_state", state_o, 2);
    chk("rmid_credit", credit, 11);
    chk("rmid_coin", vif.chg_coin, 2);
    rst = 1'b0;
    lines[0] = 1'b1;
    step();
    chk("rmid_rst_state", state_o, 0);
    chk("rmid_rst_credit", credit, 0);
    chk("rmid_rst_cvalid", vif.chg_valid, 0);
    rst = 1'b1;
    step();
    step();
    chk("rmid_held_credit", credit, 0);
    chk("rmid_held_reject", coin_reject, 0);
    lines[0] = 1'b0;
    step();
    lines[0] = 1'b1;
    step();
    lines[0] = 1'b0;
    chk("rmid_after_coin", credit, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Parametrised vending-machine controller: N selectable items, runtime-loadable price table, four coin denominations, vend handshake and greedy change return.
- Sits between the debounced board inputs (buttons, coin switches) and the existing SevenSegment display path. credit and sel_price feed the two display banks.
- Adds over the previous generation:
  - configurable item count and credit width
  - overflow rejection
  - cancel/refund
  - inactivity timeout
  - handshaked vend and change outputs

Parameters:
- NUM_ITEMS, 5, number of selectable items (≥2).
- PRICE_W, 7, width of each price and of credit.
- MAX_CREDIT, 99, credit ceiling; coins that would exceed it are rejected.
- COIN0..COIN3, 1/5/10/20, denominations of coin_in[0..3]. COIN0 must be 1 so change always terminates.
- TIMEOUT_CYC, 1000000, idle cycles with credit>0 before auto-refund.
- AUTO_CHANGE, 1, 1: refund remaining credit after every vend; 0: keep credit for further purchases.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- coin_in  in  4  level coin switches; a rising edge inserts one coin
- btn_l, btn_r, btn_ok, btn_cancel  in  1 each  level buttons; action on rising edge
- price_tbl  in  NUM_ITEMS*PRICE_W  packed prices, item i at [i*PRICE_W +: PRICE_W]
- vend_ack  in  1  dispenser accepted vend
- chg_ready  in  1  coin hopper accepts a change coin
- credit  out  PRICE_W  current credit
- sel_idx  out  clog2(NUM_ITEMS)  selected item
- sel_price  out  PRICE_W  price of selected item
- avail  out  NUM_ITEMS  bit i = (credit ≥ price i)
- vend_valid  out  1  vend request
- vend_item  out  clog2(NUM_ITEMS)  item being vended
- chg_valid  out  1  change coin request
- chg_coin  out  2  denomination index of change coin
- coin_reject  out  1  one-cycle pulse, coin refused
- deny  out  1  one-cycle pulse, confirm with insufficient credit
- state_o  out  2  FSM state

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, credit 0, sel_idx 0, timeout counter 0. vend_valid, chg_valid, coin_reject and deny are 0; chg_coin 0. Edge-detect history registers load 1s, so inputs held high through reset never fire. Reset mid-VEND or mid-CHANGE discards credit.
- Edge detect: event = input & ~previous sample, one register stage.
- FSM states: IDLE, VEND, CHANGE (2-bit encoding, one spare).
- IDLE priority, highest first: cancel > ok > coin. Navigation is independent of these.
  - cancel with credit>0 → CHANGE. With credit 0 it is ignored.
  - ok: if credit ≥ price[sel], credit -= price, vend_item ← sel, go to VEND. Otherwise deny pulses, no state change.
  - coin: exactly one coin edge with credit+COINk ≤ MAX_CREDIT → credit += COINk. Otherwise coin_reject pulses and credit is unchanged. This covers multiple simultaneous edges, an overflow, and a coin arriving in the same cycle as ok or cancel.
  - Navigation: btn_r increments sel_idx, wrapping NUM_ITEMS-1→0. btn_l decrements, wrapping 0→NUM_ITEMS-1. Simultaneous l and r is ignored.
  - Timeout: the counter clears on any accepted event and counts while credit>0 and no event. Reaching TIMEOUT_CYC-1 → CHANGE. The counter holds at 0 while credit is 0.
- VEND:
  - vend_valid=1 with vend_item stable until vend_ack is sampled high.
  - On ack: vend_valid drops the next cycle. Next state is CHANGE if AUTO_CHANGE=1 and credit>0, else IDLE.
  - Buttons are ignored. Coin edges pulse coin_reject.
- CHANGE:
  - chg_coin is the largest k with COINk ≤ credit, computed combinationally from the registered credit. chg_valid=1.
  - On chg_valid & chg_ready: credit -= COINk. Holding chg_ready high yields one coin per cycle.
  - When credit reaches 0, chg_valid drops the same cycle and the FSM returns to IDLE.
  - Coins are rejected and buttons ignored.
- avail and sel_price are combinational from the registered credit, sel_idx and price_tbl.
- Latency:
  - An input edge is seen one cycle after the input rises.
  - credit, state and sel_idx update on the following clk.
- Arithmetic:
  - credit is unsigned PRICE_W.
  - Additions are checked in PRICE_W+1 bits.
  - Subtractions occur only when proven non-negative.
- price_tbl changes take effect immediately. Prices are read only at the ok event.

Decomposition:
- vending_pkg: state encoding constants (IDLE, VEND, CHANGE), coin-index constants, clog2 function.
- Sub-module vending_edge_detect: parametrised width, synchronous active-low reset of history to 1s. Used once for the 8 input lines.

Test Plan:
- Default prices {7,5,6,10,8}, AUTO_CHANGE=1. Insert coin1 (5) then coin2 (10) → credit 15, avail 5'b11111. Select item 3, ok → vend_valid, vend_item 3, credit 5. vend_ack → CHANGE, chg_coin 1 (5), ready → credit 0, IDLE.
- credit 90, insert 20 → coin_reject one cycle, credit stays 90. Insert 5 → 95.
- sel 0, btn_l → sel 4. btn_r → sel 0. btn_l and btn_r together → sel unchanged.
- credit 6, sel 3 (price 10), ok → deny pulse, state IDLE, credit 6.
- TIMEOUT_CYC=16, credit 27, no input 16 cycles → CHANGE. chg_ready toggling 1/0 → coins 20, 5, 1, 1, each held until ready, end credit 0.
- Reset asserted during CHANGE with credit 11 → next cycle IDLE, credit 0, chg_valid 0. coin_in held high across release → no coin accepted.
